// File: rtl/packer_pkg.sv
// Shared types and width helpers for the variable-length code packer.
package packer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam int DEF_CODE_WIDTH = 10;
  localparam int DEF_LEN_WIDTH  = 4;
  localparam int DEF_WORD_WIDTH = 16;

  // The accumulator must hold a not-yet-extracted word's worth of bits
  // (at most WORD_WIDTH-1 once the threshold logic has acted) plus one code.
  function automatic int accWidth(input int codeW, input int wordW);
    return wordW + codeW - 1;
  endfunction

  // Width of a counter that has to represent 0..maxCount inclusive.
  function automatic int countWidth(input int maxCount);
    return $clog2(maxCount + 1);
  endfunction

  localparam int ACC_W_DEF  = accWidth(DEF_CODE_WIDTH, DEF_WORD_WIDTH);
  localparam int FILL_W_DEF = countWidth(ACC_W_DEF);

endpackage

// File: rtl/code_merge.sv
// Combinational accumulator update: optional word extraction shift followed
// by insertion of a masked code directly below the surviving valid bits.
module code_merge
  import packer_pkg::*;
#(
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int FILL_W     = FILL_W_DEF
) (
  input  logic [ACC_W-1:0]      acc_i,
  input  logic [FILL_W-1:0]     fill_i,
  input  logic [CODE_WIDTH-1:0] code_i,
  input  logic [FILL_W-1:0]     len_i,
  input  logic                  append_i,
  input  logic                  shift_i,
  output logic [ACC_W-1:0]      acc_o
);

  localparam logic [FILL_W-1:0] ACC_F  = FILL_W'(ACC_W);
  localparam logic [FILL_W-1:0] WORD_F = FILL_W'(WORD_WIDTH);

  logic [ACC_W-1:0]  baseAcc;
  logic [FILL_W-1:0] baseFill;
  logic [ACC_W-1:0]  codeExt;
  logic [FILL_W-1:0] insertPos;

  // Shift out the extracted word first so the new code lands at the post-shift
  // position; bits of the code above len_i are dropped by the mask.
  always_comb begin
    baseAcc   = shift_i ? (acc_i << WORD_WIDTH) : acc_i;
    baseFill  = shift_i ? (fill_i - WORD_F) : fill_i;
    codeExt   = {{(ACC_W - CODE_WIDTH){1'b0}}, code_i} & ~({ACC_W{1'b1}} << len_i);
    insertPos = ACC_F - baseFill - len_i;
    acc_o     = baseAcc;
    if (append_i) begin
      acc_o = baseAcc | (codeExt << insertPos);
    end
  end

endmodule

// File: rtl/code_packer.sv
// Variable-length code packer: concatenates codes MSB-first and emits
// fixed-width words, closing each frame with a zero-padded counted last word.
module code_packer
  import packer_pkg::*;
#(
  parameter int CODE_WIDTH = DEF_CODE_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [CODE_WIDTH-1:0]               in_code,
  input  logic [LEN_WIDTH-1:0]                in_len,
  input  logic                                flush,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WORD_WIDTH-1:0]               out_word,
  output logic [countWidth(WORD_WIDTH)-1:0]   out_bits,
  output logic                                out_last,
  output logic                                len_err
);

  localparam int ACC_W  = accWidth(CODE_WIDTH, WORD_WIDTH);
  localparam int FILL_W = countWidth(ACC_W);
  localparam int BITS_W = countWidth(WORD_WIDTH);

  localparam logic [FILL_W-1:0]    WORD_F = FILL_W'(WORD_WIDTH);
  localparam logic [FILL_W-1:0]    CODE_F = FILL_W'(CODE_WIDTH);
  localparam logic [LEN_WIDTH-1:0] CODE_L = LEN_WIDTH'(CODE_WIDTH);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              outValid_q, outValid_d;
  logic [WORD_WIDTH-1:0] outWord_q, outWord_d;
  logic [BITS_W-1:0] outBits_q, outBits_d;
  logic              outLast_q, outLast_d;
  logic              lenErr_q, lenErr_d;

  logic              slotFree;
  logic              haveWord;
  logic              doExtract;
  logic              doResidual;
  logic              inReady;
  logic              doAccept;
  logic              lenOver;
  logic [FILL_W-1:0] lenClamp;
  logic [ACC_W-1:0]  mergedAcc;

  assign slotFree   = !outValid_q || out_ready;
  assign haveWord   = (fill_q >= WORD_F);
  assign doExtract  = haveWord && slotFree;
  assign doResidual = (state_q == DRAIN) && !haveWord && slotFree;
  assign inReady    = (state_q == RUN) && (!haveWord || doExtract);
  assign doAccept   = in_valid && inReady;
  assign lenOver    = (in_len > CODE_L);
  assign lenClamp   = lenOver ? CODE_F : FILL_W'(in_len);

  code_merge #(
    .CODE_WIDTH (CODE_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .ACC_W      (ACC_W),
    .FILL_W     (FILL_W)
  ) u_merge (
    .acc_i    (acc_q),
    .fill_i   (fill_q),
    .code_i   (in_code),
    .len_i    (lenClamp),
    .append_i (doAccept),
    .shift_i  (doExtract),
    .acc_o    (mergedAcc)
  );

  // Next-state logic: word extraction, code accept, and the RUN/DRAIN frame
  // closing sequence that loads the residual word and clears the accumulator.
  always_comb begin
    state_d    = state_q;
    acc_d      = mergedAcc;
    fill_d     = fill_q - (doExtract ? WORD_F : '0) + (doAccept ? lenClamp : '0);
    outValid_d = outValid_q && !out_ready;
    outWord_d  = outWord_q;
    outBits_d  = outBits_q;
    outLast_d  = outLast_q;
    lenErr_d   = lenErr_q || (doAccept && lenOver);

    if (doExtract) begin
      outValid_d = 1'b1;
      outWord_d  = acc_q[ACC_W-1 -: WORD_WIDTH];
      outBits_d  = BITS_W'(WORD_WIDTH);
      outLast_d  = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (doResidual) begin
          outValid_d = 1'b1;
          outWord_d  = acc_q[ACC_W-1 -: WORD_WIDTH];
          outBits_d  = BITS_W'(fill_q);
          outLast_d  = 1'b1;
          acc_d      = '0;
          fill_d     = '0;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and output registers; reset drops partial bits and any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      acc_q      <= '0;
      fill_q     <= '0;
      outValid_q <= 1'b0;
      outWord_q  <= '0;
      outBits_q  <= '0;
      outLast_q  <= 1'b0;
      lenErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      outValid_q <= outValid_d;
      outWord_q  <= outWord_d;
      outBits_q  <= outBits_d;
      outLast_q  <= outLast_d;
      lenErr_q   <= lenErr_d;
    end
  end

  assign in_ready  = inReady;
  assign out_valid = outValid_q;
  assign out_word  = outWord_q;
  assign out_bits  = outBits_q;
  assign out_last  = outLast_q;
  assign len_err   = lenErr_q;

endmodule

// File: tb/tb_code_packer.sv
// Self-checking bench for code_packer: directed cases plus random traffic
// compared against a bit-queue reference model of the frame stream.
module tb_code_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_code;
  logic [3:0]  in_len;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [4:0]  out_bits;
  logic        out_last;
  logic        len_err;

  code_packer #(
    .CODE_WIDTH (10),
    .LEN_WIDTH  (4),
    .WORD_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_len    (in_len),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [4:0]  bits;
    logic        last;
  } exp_t;

  exp_t  expQ[$];
  bit    bitQ[$];
  int    compared = 0;
  int    mismatched = 0;
  bit    flushPending = 0;
  bit    lenErrExp = 0;
  bit    prevStall = 0;
  logic [15:0] prevWord;
  logic [4:0]  prevBits;
  logic        prevLast;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cut every complete 16-bit group off the front of the frame bit stream.
  task automatic makeFullWords();
    exp_t e;
    while (bitQ.size() >= 16) begin
      e.word = '0;
      for (int i = 0; i < 16; i++) e.word = {e.word[14:0], bitQ.pop_front()};
      e.bits = 5'd16;
      e.last = 1'b0;
      expQ.push_back(e);
    end
  endtask

  // Close the frame: whatever bits remain, left-aligned and zero padded.
  task automatic makeResidual();
    exp_t e;
    int   n;
    n = bitQ.size();
    e.word = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) e.word = {e.word[14:0], bitQ.pop_front()};
      else       e.word = {e.word[14:0], 1'b0};
    end
    e.bits = 5'(n);
    e.last = 1'b1;
    expQ.push_back(e);
  endtask

  // Evaluate what the coming clock edge will see and update the model.
  task automatic modelCycle();
    exp_t e;
    int   l;
    checkOutput("len_err", len_err, lenErrExp);
    if (prevStall) begin
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_word", out_word, prevWord);
      checkOutput("hold_bits", out_bits, prevBits);
      checkOutput("hold_last", out_last, prevLast);
    end
    prevStall = out_valid && !out_ready;
    prevWord  = out_word;
    prevBits  = out_bits;
    prevLast  = out_last;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_word", out_word, e.word);
        checkOutput("out_bits", out_bits, e.bits);
        checkOutput("out_last", out_last, e.last);
        if (e.last) flushPending = 0;
      end
    end
    if (in_valid && in_ready) begin
      l = (in_len > 4'd10) ? 10 : int'(in_len);
      if (in_len > 4'd10) lenErrExp = 1;
      for (int i = l - 1; i >= 0; i--) bitQ.push_back(in_code[i]);
      makeFullWords();
    end
    if (flush && !flushPending) begin
      flushPending = 1;
      makeResidual();
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] code, input logic [3:0] len,
                               input logic fl, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_code   = code;
    in_len    = len;
    flush     = fl;
    out_ready = ordy;
    #1;
    modelCycle();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = '0;
    in_len    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_word", out_word, 0);
    checkOutput("rst_out_bits", out_bits, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_len_err", len_err, 0);
    expQ.delete();
    bitQ.delete();
    flushPending = 0;
    lenErrExp = 0;
    prevStall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  accepts;
    bit  drainFlushed;
    logic fl;
    rst_n = 1'b0;
    in_valid = 1'b0; in_code = '0; in_len = '0; flush = 1'b0; out_ready = 1'b0;

    doReset();

    // Basic pack: ten ones then six zeros form one full word.
    applyStimulus(1, 10'h3FF, 4'd10, 0, 1);
    applyStimulus(1, 10'h000, 4'd6, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("basic_valid", out_valid, 1);
    checkOutput("basic_word", out_word, 16'hFFC0);
    checkOutput("basic_bits", out_bits, 16);
    checkOutput("basic_last", out_last, 0);

    // Backpressure: 40 bits fit (16 held at the output, 24 buffered).
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 10'h155, 4'd10, 0, 0);
      if (in_ready) accepts++;
    end
    checkOutput("bp_accepts", accepts, 4);
    checkOutput("bp_in_ready", in_ready, 0);
    checkOutput("bp_word", out_word, 16'h5555);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("bp_next_valid", out_valid, 1);
    checkOutput("bp_next_word", out_word, 16'h5555);
    applyStimulus(0, 10'h000, 4'd0, 1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 10'h000, 4'd0, 0, 1);

    // Flush with residual; the code in the flush cycle belongs to the frame,
    // and a second flush while draining is ignored.
    applyStimulus(1, 10'h005, 4'd3, 1, 1);
    applyStimulus(0, 10'h000, 4'd0, 1, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("res_word", out_word, 16'hA000);
    checkOutput("res_bits", out_bits, 3);
    checkOutput("res_last", out_last, 1);
    checkOutput("res_in_ready", in_ready, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("res_single_last", out_valid, 0);

    // Zero length, over-long length, and an empty flush.
    applyStimulus(1, 10'h3FF, 4'd0, 0, 1);
    applyStimulus(1, 10'h3FF, 4'd12, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("lenerr_set", len_err, 1);
    applyStimulus(0, 10'h000, 4'd0, 1, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("clamp_word", out_word, 16'hFFC0);
    checkOutput("clamp_bits", out_bits, 10);
    applyStimulus(0, 10'h000, 4'd0, 1, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("empty_valid", out_valid, 1);
    checkOutput("empty_word", out_word, 0);
    checkOutput("empty_bits", out_bits, 0);
    checkOutput("empty_last", out_last, 1);

    // Reset mid-frame discards the partial bits.
    applyStimulus(1, 10'h07F, 4'd7, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    doReset();
    applyStimulus(0, 10'h000, 4'd0, 1, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);
    checkOutput("rstmid_valid", out_valid, 1);
    checkOutput("rstmid_bits", out_bits, 0);
    checkOutput("rstmid_last", out_last, 1);
    applyStimulus(0, 10'h000, 4'd0, 0, 1);

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      fl = !flushPending && ($urandom_range(0, 99) < 3);
      applyStimulus(($urandom_range(0, 9) < 7), 10'($urandom), 4'($urandom_range(0, 11)),
                    fl, ($urandom_range(0, 9) < 6));
    end

    // Close the last frame and let every expected word come out.
    drainFlushed = 0;
    for (int i = 0; i < 300 && (expQ.size() != 0 || flushPending || !drainFlushed); i++) begin
      fl = !flushPending && !drainFlushed;
      if (fl) drainFlushed = 1;
      applyStimulus(0, 10'h000, 4'd0, fl, 1);
    end
    checkOutput("drain_empty", expQ.size(), 0);
    checkOutput("drain_pending", flushPending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
